// File: rtl/aes_inv_cipher_seq_pkg.sv
// Shared AES definitions for the inverse cipher: inverse S-box, GF(2^8) multiply
// helpers (reduction polynomial 0x11B), round-count constants and FSM states.
package aes_pkg;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } fsm_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] x2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] x9(input logic [7:0] b);
    return x2(x2(x2(b))) ^ b;
  endfunction

  function automatic logic [7:0] x0b(input logic [7:0] b);
    return x2(x2(x2(b))) ^ x2(b) ^ b;
  endfunction

  function automatic logic [7:0] x0d(input logic [7:0] b);
    return x2(x2(x2(b))) ^ x2(x2(b)) ^ b;
  endfunction

  function automatic logic [7:0] x0e(input logic [7:0] b);
    return x2(x2(x2(b))) ^ x2(x2(b)) ^ x2(b);
  endfunction

endpackage

// File: rtl/aes_inv_cipher_seq_if.sv
// Block-in / block-out handshakes plus the round-key store lookup of the
// inverse cipher sequencer.
interface aes_inv_cipher_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   key_idx;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, key_in, out_ready,
    output in_ready, key_idx, out_valid, out_data, busy
  );

  // Block source, key store and plaintext sink side.
  modport master (
    output in_valid, in_data, key_in, out_ready,
    input  in_ready, key_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_inv_cipher_seq_round.sv
// Combinational AES decryption round: InvShiftRows, InvSubBytes, AddRoundKey and
// (except on the last round) InvMixColumns. Byte i sits at bits [127-8i -: 8].
module aes_inv_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  always_comb begin
    data_o = '0;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = data_i[127-32*c -: 8];
      a1 = data_i[119-32*c -: 8];
      a2 = data_i[111-32*c -: 8];
      a3 = data_i[103-32*c -: 8];
      data_o[127-32*c -: 8] = x0e(a0) ^ x0b(a1) ^ x0d(a2) ^ x9(a3);
      data_o[119-32*c -: 8] = x9(a0)  ^ x0e(a1) ^ x0b(a2) ^ x0d(a3);
      data_o[111-32*c -: 8] = x0d(a0) ^ x9(a1)  ^ x0e(a2) ^ x0b(a3);
      data_o[103-32*c -: 8] = x0b(a0) ^ x0d(a1) ^ x9(a2)  ^ x0e(a3);
    end
  end
endmodule

module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  input  logic         last_i,
  output logic [127:0] state_o
);
  logic [127:0] sub_q_free;
  logic [127:0] ark;
  logic [127:0] imc;

  // Row r rotates right by r: output column c takes input column (c - r) mod 4.
  always_comb begin
    sub_q_free = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_q_free[127-8*(r+4*c) -: 8] =
          inv_sbox(state_i[127-8*(r+4*((c+4-r)%4)) -: 8]);
      end
    end
  end

  assign ark = sub_q_free ^ rkey_i;

  aes_inv_mix_columns u_imc (
    .data_i (ark),
    .data_o (imc)
  );

  assign state_o = last_i ? ark : imc;
endmodule

// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES inverse cipher: one shared round datapath, one round per clock,
// round keys read combinationally from an external store by index.
module aes_inv_cipher_seq
  import aes_pkg::*;
#(
  parameter int unsigned NR = NR_128
) (
  input  logic                clk,
  input  logic                rst,
  aes_inv_cipher_seq_if.slave bus
);
  localparam logic [3:0] NR4 = 4'(NR);

  fsm_e         fsm_q;
  logic [127:0] state_q;
  logic [3:0]   round_cnt_q;
  logic [3:0]   key_idx_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;
  logic [127:0] round_d;

  aes_inv_round u_round (
    .state_i (state_q),
    .rkey_i  (bus.key_in),
    .last_i  (round_cnt_q == 4'd0),
    .state_o (round_d)
  );

  // key_idx_q tracks round_cnt_q during ROUND and parks at NR otherwise, so the
  // store already presents the initial key while waiting in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      round_cnt_q <= '0;
      key_idx_q   <= NR4;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (fsm_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_q     <= bus.in_data ^ bus.key_in;
            round_cnt_q <= NR4 - 4'd1;
            key_idx_q   <= NR4 - 4'd1;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            fsm_q       <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          state_q <= round_d;
          if (round_cnt_q == 4'd0) begin
            key_idx_q   <= NR4;
            out_valid_q <= 1'b1;
            fsm_q       <= ST_DONE;
          end else begin
            round_cnt_q <= round_cnt_q - 4'd1;
            key_idx_q   <= round_cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= ST_IDLE;
          end
        end
        default: begin
          fsm_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = state_q;
  assign bus.key_idx   = key_idx_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_aes_inv_cipher_seq.sv
// Bench for aes_inv_cipher_seq: FIPS-197 vectors, backpressure, busy drop,
// mid-round reset and back-to-back blocks against an independent AES model.
module tb_aes_inv_cipher_seq;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [127:0] rk [0:10];
  logic [7:0]   sbx [0:255];
  logic [127:0] exp_q [$];
  logic [127:0] exp_v;

  aes_inv_cipher_seq_if bus ();

  aes_inv_cipher_seq #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.key_in = (bus.key_idx <= 4'd10) ? rk[bus.key_idx] : 128'h0;

  // Independent forward-AES model: S-box from the GF inverse plus affine map.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int k);
    return 8'((b << k) | (b >> (8 - k)));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
      sbx[x] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbx[t[31:24]], sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    o = pt ^ rk[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbx[o[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
          s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i] ^ rk[rnd][127-8*i -: 8];
    end
    return o;
  endfunction

  task automatic wait_out(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (bus.out_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.out_data !== 128'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    total++; if (bus.key_idx !== 4'd10) begin bad++; $display("FAIL reset_key_idx got=%0d exp=10", bus.key_idx); end
  endtask

  task automatic test_c1();
    int t0;
    expand(C1_KEY);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = C1_CT;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL c1_in_ready got=%b exp=1", bus.in_ready); end
    exp_q.push_back(C1_PT);
    t0 = cyc;
    for (int k = 0; k <= 10; k++) begin
      total++;
      if (bus.key_idx !== 4'(10 - k)) begin bad++; $display("FAIL c1_key_idx step=%0d got=%0d exp=%0d", k, bus.key_idx, 10 - k); end
      @(negedge clk);
      if (k == 0) bus.in_valid = 1'b0;
    end
    total++; if (bus.out_valid !== 1'b1 || cyc - t0 != 11) begin bad++; $display("FAIL c1_latency got_valid=%b cycles=%0d exp=11", bus.out_valid, cyc - t0); end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    total++; if (bus.out_data !== exp_v) begin bad++; $display("FAIL c1_data got=%h exp=%h", bus.out_data, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_appb();
    bit ok;
    expand(B_KEY);
    bus.in_valid = 1'b1; bus.in_data = B_CT;
    exp_q.push_back(B_PT);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL appb_timeout got=no_out exp=out_valid"); end
    else begin
      exp_v = exp_q.pop_front();
      if (bus.out_data !== exp_v) begin bad++; $display("FAIL appb_data got=%h exp=%h", bus.out_data, exp_v); end
    end
    @(negedge clk);
    exp_q.delete();
    expand(C1_KEY);
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [127:0] held;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = C1_CT;
    exp_q.push_back(C1_PT);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_timeout got=no_out exp=out_valid"); end
    held = bus.out_data;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    total++; if (held !== exp_v) begin bad++; $display("FAIL bp_data got=%h exp=%h", held, exp_v); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_v || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got_valid=%b got_ready=%b got_busy=%b got_data=%h exp_data=%h",
                 i, bus.out_valid, bus.in_ready, bus.busy, bus.out_data, exp_v);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL bp_release got_ready=%b got_valid=%b got_busy=%b exp=1/0/0", bus.in_ready, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_busy_drop();
    int t0, t1;
    bit ok;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = C1_CT;
    exp_q.push_back(C1_PT);
    t0 = cyc;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(1, 0));
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL drop_in_ready round=%0d got=%b exp=0", k, bus.in_ready); end
    end
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = C1_CT;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_v || cyc - t0 != 11) begin
      bad++; $display("FAIL drop_first got_valid=%b got=%h exp=%h cycles=%0d", bus.out_valid, bus.out_data, exp_v, cyc - t0);
    end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL drop_done_ready got=%b exp=0", bus.in_ready); end
    exp_q.push_back(C1_PT);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL drop_second_accept got=%b exp=1", bus.in_ready); end
    t1 = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(20, ok);
    total++;
    if (!ok || cyc - t1 != 11) begin bad++; $display("FAIL drop_second_latency got=%0d exp=11", cyc - t1); end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    total++; if (bus.out_data !== exp_v) begin bad++; $display("FAIL drop_second_data got=%h exp=%h", bus.out_data, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = C1_CT;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_data !== 128'h0 || bus.key_idx !== 4'd10) begin
      bad++;
      $display("FAIL midrst_state got_ready=%b got_valid=%b got_busy=%b got_data=%h got_idx=%0d exp=1/0/0/0/10",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_data, bus.key_idx);
    end
    bus.in_valid = 1'b1; bus.in_data = C1_CT;
    exp_q.push_back(C1_PT);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midrst_timeout got=no_out exp=out_valid"); end
    else begin
      exp_v = exp_q.pop_front();
      if (bus.out_data !== exp_v) begin bad++; $display("FAIL midrst_data got=%h exp=%h", bus.out_data, exp_v); end
    end
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [4];
    logic [127:0] cts [4];
    int acc_cyc [4];
    int n_acc, n_out;
    bit adv;
    n_acc = 0; n_out = 0; adv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pts[i] = {$urandom, $urandom, $urandom, $urandom};
      cts[i] = enc(pts[i]);
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = cts[0];
    for (int g = 0; g < 80 && n_out < 4; g++) begin
      if (bus.out_valid === 1'b1) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        total++;
        if (bus.out_data !== exp_v) begin bad++; $display("FAIL b2b_data blk=%0d got=%h exp=%h", n_out, bus.out_data, exp_v); end
        n_out++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1 && n_acc < 4) begin
        acc_cyc[n_acc] = cyc;
        exp_q.push_back(pts[n_acc]);
        n_acc++;
        adv = 1'b1;
      end
      @(negedge clk);
      if (adv) begin
        adv = 1'b0;
        if (n_acc < 4) bus.in_data = cts[n_acc];
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    total++; if (n_out != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", n_out); end
    for (int i = 1; i < n_acc; i++) begin
      total++;
      if (acc_cyc[i] - acc_cyc[i-1] != 12) begin bad++; $display("FAIL b2b_spacing blk=%0d got=%0d exp=12", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    init_sbox();
    expand(C1_KEY);
    @(negedge clk);
    test_reset();
    test_c1();
    test_appb();
    test_backpressure();
    test_busy_drop();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
